// File: rtl/upscale_requant.sv
// Output requantizer: rounds the signed 4-tap dot-product sum to an 8-bit clamped pixel,
// tags it with line/frame position and tracks clamp statistics, over a 2-stage valid/ready pipe.
module upscale_requant #(
    parameter int FRAC_BITS   = 7,
    parameter int LINE_PIXELS = 640,
    parameter int FRAME_LINES = 480,
    parameter int STAT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [19:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_pixel,
    output logic              out_sol,
    output logic              out_eol,
    output logic              out_eof,
    input  logic              clr_stats,
    output logic [STAT_W-1:0] sat_hi_cnt,
    output logic [STAT_W-1:0] sat_lo_cnt
);

    localparam int COL_W = (LINE_PIXELS > 1) ? $clog2(LINE_PIXELS) : 1;
    localparam int ROW_W = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_PIXELS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FRAME_LINES - 1);
    localparam logic [20:0]      HALF     = 21'd1 << (FRAC_BITS - 1);

    // Round half toward +inf: add half an LSB, then floor via arithmetic shift.
    logic [20:0]        t_sum;
    logic signed [20:0] q_val;
    logic               c_lo;
    logic               c_hi;
    logic [7:0]         c_pix;

    assign t_sum = {in_data[19], in_data} + HALF;
    assign q_val = $signed(t_sum) >>> FRAC_BITS;
    assign c_lo  = q_val[20];
    assign c_hi  = !q_val[20] && (|q_val[19:8]);
    assign c_pix = c_lo ? 8'd0 : (c_hi ? 8'hFF : q_val[7:0]);

    logic       s1_valid_q;
    logic [7:0] s1_pix_q;
    logic       s1_hi_q;
    logic       s1_lo_q;
    logic       s2_valid_q;
    logic [7:0] s2_pix_q;
    logic       s2_hi_q;
    logic       s2_lo_q;
    logic       s2_load;
    logic       out_fire;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;
    assign out_fire = s2_valid_q && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= 8'd0;
            s1_hi_q    <= 1'b0;
            s1_lo_q    <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_pix_q <= c_pix;
                s1_hi_q  <= c_hi;
                s1_lo_q  <= c_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_pix_q   <= 8'd0;
            s2_hi_q    <= 1'b0;
            s2_lo_q    <= 1'b0;
        end else if (s2_load) begin
            s2_valid_q <= s1_valid_q;
            s2_pix_q   <= s1_pix_q;
            s2_hi_q    <= s1_hi_q;
            s2_lo_q    <= s1_lo_q;
        end
    end

    logic [COL_W-1:0] col_q;
    logic [ROW_W-1:0] row_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (out_fire) begin
            if (col_q == COL_LAST) begin
                col_q <= '0;
                row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign out_pixel = s2_pix_q;
    assign out_sol   = s2_valid_q && (col_q == '0);
    assign out_eol   = s2_valid_q && (col_q == COL_LAST);
    assign out_eof   = out_eol && (row_q == ROW_LAST);

    // Index 0 counts low clamps, index 1 counts high clamps; both saturate at all-ones.
    logic [1:0] sat_flag;
    assign sat_flag = {s2_hi_q, s2_lo_q};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sat
            logic [STAT_W-1:0] cnt_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else if (clr_stats) begin
                    cnt_q <= '0;
                end else if (out_fire && sat_flag[gi] && (cnt_q != '1)) begin
                    cnt_q <= cnt_q + {{(STAT_W-1){1'b0}}, 1'b1};
                end
            end
        end
    endgenerate

    assign sat_lo_cnt = g_sat[0].cnt_q;
    assign sat_hi_cnt = g_sat[1].cnt_q;

endmodule

// File: tb/tb_upscale_requant.sv
// Directed bench for upscale_requant: rounding/clamp table, clear priority, backpressure,
// framing flags, counter stick and asynchronous reset mid-stream.
module tb_upscale_requant;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [19:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_pixel;
    logic        out_sol;
    logic        out_eol;
    logic        out_eof;
    logic        clr_stats;
    logic [1:0]  sat_hi_cnt;
    logic [1:0]  sat_lo_cnt;

    upscale_requant #(
        .FRAC_BITS  (7),
        .LINE_PIXELS(4),
        .FRAME_LINES(2),
        .STAT_W     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pixel (out_pixel),
        .out_sol   (out_sol),
        .out_eol   (out_eol),
        .out_eof   (out_eof),
        .clr_stats (clr_stats),
        .sat_hi_cnt(sat_hi_cnt),
        .sat_lo_cnt(sat_lo_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [19:0] din;
        int          pix;
        int          hi;
        int          lo;
    } vec_t;

    vec_t vecs [14];

    // Pseudo-random out_ready pattern, LSB first; starts with a stall to fill both stages.
    localparam logic [15:0] READY_PAT = 16'b1101_1010_0110_1000;

    initial begin
        int k_in;
        int k_out;
        int occ;
        int beat;
        logic have_stall;
        logic [7:0] stall_pix;
        logic in_f;
        logic out_f;

        vecs[0]  = '{20'd63,    0,   0, 0};
        vecs[1]  = '{20'd64,    1,   0, 0};
        vecs[2]  = '{20'd191,   1,   0, 0};
        vecs[3]  = '{20'd192,   2,   0, 0};
        vecs[4]  = '{20'hFFFFF, 0,   0, 0};
        vecs[5]  = '{20'h07FFF, 255, 1, 0};
        vecs[6]  = '{20'hFFF38, 0,   0, 1};
        vecs[7]  = '{20'd32639, 255, 0, 0};
        vecs[8]  = '{20'd32703, 255, 0, 0};
        vecs[9]  = '{20'd32704, 255, 1, 0};
        vecs[10] = '{20'hFFFC0, 0,   0, 0};
        vecs[11] = '{20'hFFFBF, 0,   0, 1};
        vecs[12] = '{20'h7FFFF, 255, 1, 0};
        vecs[13] = '{20'h80000, 0,   0, 1};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr_stats = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_pixel", out_pixel, 0);
        chk("rst_sat_hi", sat_hi_cnt, 0);
        chk("rst_sat_lo", sat_lo_cnt, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Rounding / clamp table: one isolated beat each, counters cleared beforehand.
        for (int i = 0; i < 14; i++) begin
            clr_stats = 1'b1; out_ready = 1'b1;
            tick();
            clr_stats = 1'b0;
            in_valid = 1'b1; in_data = vecs[i].din;
            tick();
            in_valid = 1'b0;
            chk($sformatf("v%0d_lat1_valid", i), out_valid, 0);
            tick();
            chk($sformatf("v%0d_lat2_valid", i), out_valid, 1);
            chk($sformatf("v%0d_pixel", i), out_pixel, vecs[i].pix);
            tick();
            chk($sformatf("v%0d_drained", i), out_valid, 0);
            chk($sformatf("v%0d_sat_hi", i), sat_hi_cnt, vecs[i].hi);
            chk($sformatf("v%0d_sat_lo", i), sat_lo_cnt, vecs[i].lo);
            $display("vec %0d din=%05h pix=%0d hi=%0d lo=%0d", i, vecs[i].din, out_pixel,
                     sat_hi_cnt, sat_lo_cnt);
        end

        // Clear coinciding with a saturating transfer must win.
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        in_valid = 1'b1; in_data = 20'h07FFF; tick(); in_valid = 1'b0; tick(); tick();
        chk("clr_pre_hi", sat_hi_cnt, 1);
        in_valid = 1'b1; in_data = 20'h07FFF; tick(); in_valid = 1'b0; tick();
        chk("clr_s2_valid", out_valid, 1);
        clr_stats = 1'b1; tick(); clr_stats = 1'b0;
        chk("clr_priority_hi", sat_hi_cnt, 0);
        $display("clr+sat transfer: sat_hi_cnt=%0d", sat_hi_cnt);

        // Counter stick at all-ones.
        in_valid = 1'b1; in_data = 20'h07FFF;
        for (int i = 0; i < 5; i++) tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("stick_hi", sat_hi_cnt, 3);
        chk("stick_lo", sat_lo_cnt, 0);
        $display("stick: sat_hi_cnt=%0d after 5 high beats", sat_hi_cnt);

        // Backpressure stream, values 0x80*k, expect pixel k in order.
        k_in = 0; k_out = 0; occ = 0; have_stall = 1'b0; stall_pix = '0;
        for (int cyc = 0; cyc < 200 && k_out < 10; cyc++) begin
            out_ready = READY_PAT[cyc % 16];
            in_valid  = (k_in < 10);
            in_data   = 20'(k_in * 128);
            #1;
            chk("bp_in_ready", in_ready, (occ == 2 && !out_ready) ? 0 : 1);
            if (have_stall) begin
                chk("bp_stall_valid", out_valid, 1);
                chk("bp_stall_pixel", out_pixel, stall_pix);
            end
            in_f  = in_valid && in_ready;
            out_f = out_valid && out_ready;
            if (out_f) begin
                chk("bp_order", out_pixel, k_out);
                $display("bp beat %0d pixel=%0d", k_out, out_pixel);
                k_out++;
            end
            have_stall = out_valid && !out_ready;
            stall_pix  = out_pixel;
            if (in_f) k_in++;
            occ = occ + int'(in_f) - int'(out_f);
            @(posedge clk); #1;
        end
        chk("bp_count", k_out, 10);
        in_valid = 1'b0; out_ready = 1'b1;

        // Framing: reset to align position, then 16 transfers with out_ready held high.
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        beat = 0; k_in = 0;
        for (int cyc = 0; cyc < 40 && beat < 16; cyc++) begin
            in_valid = (k_in < 16);
            in_data  = 20'd0;
            #1;
            if (in_valid && in_ready) k_in++;
            if (out_valid && out_ready) begin
                beat++;
                chk($sformatf("frm%0d_sol", beat), out_sol, (beat % 4 == 1) ? 1 : 0);
                chk($sformatf("frm%0d_eol", beat), out_eol, (beat % 4 == 0) ? 1 : 0);
                chk($sformatf("frm%0d_eof", beat), out_eof, (beat % 8 == 0) ? 1 : 0);
                $display("frame beat %0d sol=%0d eol=%0d eof=%0d", beat, out_sol, out_eol, out_eof);
            end
            @(posedge clk); #1;
        end
        chk("frm_count", beat, 16);
        in_valid = 1'b0;
        tick();

        // Reset mid-stream with both stages full.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 20'h00080;
        tick(); tick();
        in_valid = 1'b0;
        chk("rs_full_in_ready", in_ready, 0);
        chk("rs_full_valid", out_valid, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rs_async_valid", out_valid, 0);
        chk("rs_async_in_ready", in_ready, 1);
        chk("rs_async_sol", out_sol, 0);
        $display("async reset: out_valid=%0d in_ready=%0d", out_valid, in_ready);
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 20'h00100;
        tick();
        in_valid = 1'b0;
        tick();
        chk("rs_next_valid", out_valid, 1);
        chk("rs_next_pixel", out_pixel, 2);
        chk("rs_next_sol", out_sol, 1);
        chk("rs_next_eol", out_eol, 0);
        $display("after reset: pixel=%0d sol=%0d", out_pixel, out_sol);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/upscale_requant.md
# upscale_requant

Output requantizer for the upscaler datapath. Consumes the 20-bit two's-complement sum from the 4-tap dot product and rounds it to 8-bit unsigned pixels, with clamping. Tags each pixel with line and frame position and passes it downstream over a valid/ready interface with full backpressure. Keeps saturation statistics for weight-set debug.

## Interface
- FRAC_BITS, 7, fractional bits of the weight format; result is shifted right by this amount (range 1..12)
- LINE_PIXELS, 640, output pixels per line (>= 2)
- FRAME_LINES, 480, output lines per frame (>= 1)
- STAT_W, 16, width of each saturation counter
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  in_data is valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  20  signed dot-product sum
- out_valid  out  1  out_pixel is valid
- out_ready  in  1  downstream accepts this cycle
- out_pixel  out  8  unsigned rounded, clamped pixel
- out_sol  out  1  start of line (first pixel of a line), gated by out_valid
- out_eol  out  1  end of line, gated by out_valid
- out_eof  out  1  last pixel of frame, gated by out_valid
- clr_stats  in  1  synchronous clear of both saturation counters
- sat_hi_cnt  out  STAT_W  accepted pixels clamped to 255
- sat_lo_cnt  out  STAT_W  accepted pixels clamped to 0

## Operation
- Arithmetic, sign-extended to 21 bits: t = in_data + 2^(FRAC_BITS-1); q = t >>> FRAC_BITS (arithmetic shift). Rounding is half toward +infinity.
- Clamp rules:
  - q < 0 gives 0 and sets sat_lo.
  - q > 255 gives 255 and sets sat_hi.
  - Otherwise the pixel is q[7:0].
  - A value that rounds to exactly 0 or 255 is not a saturation.
- Pipeline has two register stages:
  - S1 holds the clamped pixel and its two saturation flags.
  - S2 is the output register: out_pixel, out_valid, and the flags.
- Handshake:
  - S2 loads when it is empty or out_ready=1.
  - S1 advances when S2 loads.
  - in_ready = !s1_valid || s2_load. This is combinational, with no dependence on in_valid.
  - A transfer occurs when valid&&ready.
  - S2 contents are held stable while out_valid=1 && out_ready=0.
- Position counters col (0..LINE_PIXELS-1) and row (0..FRAME_LINES-1):
  - They advance only on an output transfer.
  - col wraps to 0 at LINE_PIXELS-1, and row increments at that wrap.
  - row wraps to 0 after FRAME_LINES-1.
- Position flags, each ANDed with out_valid:
  - out_sol = (col==0)
  - out_eol = (col==LINE_PIXELS-1)
  - out_eof = out_eol && (row==FRAME_LINES-1)
- Saturation counters:
  - Increment on an output transfer whose pixel carries the matching flag.
  - Stick at all-ones; they never wrap.
  - clr_stats has priority: a clear coinciding with an increment leaves 0.
- Reset, asynchronous:
  - All pipeline valids, counters and statistics go to 0.
  - out_pixel = 0 and all out_* flags = 0.
  - in_ready = 1 immediately, because the pipeline is empty.
- Reset mid-transfer drops any in-flight pixels. The next accepted pixel is col 0, row 0.

## Timing
- Latency: a pixel accepted at edge N is presented with out_valid at edge N+2 when out_ready is held high.
- Throughput: 1 pixel/clock sustained with out_ready=1.
- No bubble is inserted when out_ready toggles.
- Buffering: with out_ready=0, two pixels are accepted (S1 and S2 fill), then in_ready falls in the following cycle.
- Release: the first cycle out_ready returns to 1, in_ready=1 combinationally in that same cycle.
- Data never overwrites an unaccepted S2.
- Simultaneous S2 drain and S1 refill in one cycle is legal and required.
- Statistics and position counters update at the edge of the output transfer. Their new value is visible the next cycle.

## Test plan
- Rounding, FRAC_BITS=7, out_ready=1:
  - in_data 63 gives 0; 64 gives 1; 191 gives 1; 192 gives 2.
  - 0xFFFFF (-1) gives 0 with sat_lo_cnt unchanged.
  - In every case the result appears 2 cycles after acceptance.
- Saturation:
  - 0x07FFF gives 255, with sat_hi_cnt +1.
  - 0xFFF38 (-200) gives 0, with sat_lo_cnt +1.
  - 32639 gives 255 with no count.
  - Asserting clr_stats together with a saturating transfer leaves the counter at 0.
- Backpressure:
  - Stream 10 beats, values 0x80·k, with out_ready toggling pseudo-randomly.
  - Required: output sequence equals k=0..9 in order, no drops or duplicates, out_pixel stable while stalled.
  - in_ready low only while both stages are full and out_ready=0.
- Framing, LINE_PIXELS=4, FRAME_LINES=2:
  - Over 16 transfers, out_sol on beats 1, 5, 9, 13.
  - out_eol on beats 4, 8, 12, 16.
  - out_eof on beats 8 and 16.
- Counter stick, STAT_W=2: 5 saturating-high beats leave sat_hi_cnt = 3.
- Reset mid-stream:
  - Assert rst_n low asynchronously between edges with both stages full.
  - Required: out_valid=0 and in_ready=1 immediately.
  - The next pixel after release is flagged out_sol with col 0, row 0.
